// File: rtl/mdio_init_sequencer_if.sv
// Command/response channel between the PHY init sequencer and the MDIO frame serializer.
interface mdio_init_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [4:0]  cmd_phy_addr;
    logic [4:0]  cmd_reg_addr;
    logic [15:0] cmd_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;

    // A command transfers on any posedge with cmd_valid & cmd_ready; once raised, cmd_valid and the payload
    // hold until that transfer. rsp_valid is a one-cycle pulse closing each transferred frame.
    modport master (output cmd_valid, cmd_write, cmd_phy_addr, cmd_reg_addr, cmd_wdata,
                    input  cmd_ready, rsp_valid, rsp_rdata);
    modport slave  (input  cmd_valid, cmd_write, cmd_phy_addr, cmd_reg_addr, cmd_wdata,
                    output cmd_ready, rsp_valid, rsp_rdata);
endinterface

// File: rtl/mdio_init_sequencer.sv
// Issues a fixed PHY register write table over the serializer command channel, then polls BMSR for link.
module mdio_init_sequencer #(
    parameter logic [4:0]  PHY_ADDR      = 5'h10,
    parameter int unsigned GAP_CYCLES    = 32,
    parameter int unsigned POLL_INTERVAL = 1024,
    parameter int unsigned POLL_MAX      = 255,
    parameter int unsigned RSP_TIMEOUT   = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    mdio_init_sequencer_if.master bus,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  fail_o,
    output logic                  link_up_o,
    output logic [3:0]            dbg_state_o
);
    localparam int unsigned CNT_MAX_A = (GAP_CYCLES > POLL_INTERVAL) ? GAP_CYCLES : POLL_INTERVAL;
    localparam int unsigned CNT_MAX   = (CNT_MAX_A > RSP_TIMEOUT) ? CNT_MAX_A : RSP_TIMEOUT;
    localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] POLL_LAST = CNT_W'(POLL_INTERVAL - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(RSP_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [7:0]       POLL_LIM  = 8'(POLL_MAX);
    localparam logic [4:0]       BMSR_REG  = 5'h01;

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_ISSUE      = 4'd1,
        S_WAIT_RSP   = 4'd2,
        S_GAP        = 4'd3,
        S_POLL_ISSUE = 4'd4,
        S_POLL_WAIT  = 4'd5,
        S_POLL_GAP   = 4'd6,
        S_DONE       = 4'd7,
        S_FAIL       = 4'd8
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       poll_q, poll_d;
    logic             link_q, link_d;
    logic [20:0]      entry;

    // {reg_addr, wdata}: soft reset, speed and mode setup, applied in this order.
    function automatic logic [20:0] table_entry(input logic [2:0] idx);
        logic [20:0] e;
        case (idx)
            3'd0:    e = {5'h10, 16'h0060};
            3'd1:    e = {5'h00, 16'h8140};
            3'd2:    e = {5'h14, 16'h0070};
            3'd3:    e = {5'h00, 16'h8140};
            3'd4:    e = {5'h1D, 16'h0012};
            3'd5:    e = {5'h1E, 16'h8240};
            default: e = '0;
        endcase
        return e;
    endfunction

    assign entry = table_entry(idx_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            poll_q  <= '0;
            link_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            poll_q  <= poll_d;
            link_q  <= link_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        poll_d  = poll_q;
        link_d  = link_q;
        case (state_q)
            S_IDLE, S_DONE, S_FAIL: begin
                if (start_i) begin
                    state_d = S_ISSUE;
                    idx_d   = '0;
                    cnt_d   = '0;
                    poll_d  = '0;
                    link_d  = 1'b0;
                end
            end
            S_ISSUE: begin
                if (bus.cmd_ready) begin
                    state_d = S_WAIT_RSP;
                    cnt_d   = '0;
                end
            end
            S_WAIT_RSP: begin
                // A response on the terminal-count cycle still counts as a response.
                if (bus.rsp_valid) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                end else if (cnt_q == TMO_LAST) begin
                    state_d = S_FAIL;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    if (idx_q == 3'd5) begin
                        state_d = S_POLL_ISSUE;
                        poll_d  = '0;
                    end else begin
                        state_d = S_ISSUE;
                        idx_d   = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_POLL_ISSUE: begin
                if (bus.cmd_ready) begin
                    state_d = S_POLL_WAIT;
                    cnt_d   = '0;
                    poll_d  = poll_q + 8'd1;
                end
            end
            S_POLL_WAIT: begin
                if (bus.rsp_valid) begin
                    link_d = bus.rsp_rdata[2];
                    cnt_d  = '0;
                    if (bus.rsp_rdata[2])        state_d = S_DONE;
                    else if (poll_q == POLL_LIM) state_d = S_FAIL;
                    else                         state_d = S_POLL_GAP;
                end else if (cnt_q == TMO_LAST) begin
                    state_d = S_FAIL;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_POLL_GAP: begin
                if (cnt_q == POLL_LAST) begin
                    state_d = S_POLL_ISSUE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.cmd_valid    = (state_q == S_ISSUE) || (state_q == S_POLL_ISSUE);
    assign bus.cmd_write    = (state_q == S_ISSUE);
    assign bus.cmd_phy_addr = PHY_ADDR;
    assign bus.cmd_reg_addr = (state_q == S_ISSUE)      ? entry[20:16] :
                              (state_q == S_POLL_ISSUE) ? BMSR_REG     : 5'h00;
    assign bus.cmd_wdata    = (state_q == S_ISSUE) ? entry[15:0] : 16'h0000;

    assign busy_o      = !((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_FAIL));
    assign done_o      = (state_q == S_DONE);
    assign fail_o      = (state_q == S_FAIL);
    assign link_up_o   = link_q;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_mdio_init_sequencer.sv
// Bench for mdio_init_sequencer: randomized serializer responder, command scoreboard and outcome checks.
module tb_mdio_init_sequencer;
    localparam int         GAP  = 32;
    localparam int         PINT = 1024;
    localparam int         PMAX = 3;
    localparam int         TMO  = 4096;
    localparam logic [4:0] PHY  = 5'h10;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       busy, done, fail, link_up;
    logic [3:0] dbg_state;

    mdio_init_sequencer_if bus();

    mdio_init_sequencer #(
        .PHY_ADDR(PHY), .GAP_CYCLES(GAP), .POLL_INTERVAL(PINT), .POLL_MAX(PMAX), .RSP_TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .bus(bus),
        .busy_o(busy), .done_o(done), .fail_o(fail), .link_up_o(link_up), .dbg_state_o(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard state ----------------
    int tests = 0;
    int fails = 0;
    logic [26:0]  exp_q[$];
    logic [15:0]  poll_rsp_q[$];
    logic [4:0]   tbl_reg [6] = '{5'h10, 5'h00, 5'h14, 5'h00, 5'h1D, 5'h1E};
    logic [15:0]  tbl_dat [6] = '{16'h0060, 16'h8140, 16'h0070, 16'h8140, 16'h0012, 16'h8240};
    bit           exp_done, exp_link;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: 6 table writes, then BMSR reads until bit 2 is seen or PMAX reads are used up.
    task automatic plan_run(input logic [15:0] polls[$]);
        int n_reads;
        logic [15:0] d;
        exp_done = 1'b0;
        exp_link = 1'b0;
        n_reads  = 0;
        for (int i = 0; i < 6; i++) exp_q.push_back({1'b1, PHY, tbl_reg[i], tbl_dat[i]});
        for (int i = 0; i < PMAX; i++) begin
            n_reads++;
            d = (i < polls.size()) ? polls[i] : 16'h0000;
            if (d[2]) begin
                exp_done = 1'b1;
                exp_link = 1'b1;
                break;
            end
        end
        for (int i = 0; i < n_reads; i++) exp_q.push_back({1'b0, PHY, 5'h01, 16'h0000});
        poll_rsp_q = polls;
    endtask

    // ---------------- responder (serializer model) ----------------
    int   ready_mode   = 0;   // 0: always ready, 1: random, 2: stall entry 2 for 50 cycles
    int   dmin = 20, dmax = 20;
    int   withhold_idx = -1;
    int   n_acc = 0;
    int   hold_cnt = 0;
    bit   stray_req = 0;
    bit   pending = 0;
    int   countdown = 0;
    logic [15:0] pend_data;
    bit   mon_xfer = 0, mon_xfer_read = 0;

    initial begin
        bus.cmd_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_rdata = 16'h0000;
        forever begin
            @(posedge clk);
            #1;
            bus.rsp_valid = 1'b0;
            if (!rst_n) begin
                pending = 0;
                bus.cmd_ready = 1'b0;
            end else begin
                if (pending) begin
                    if (countdown == 0) begin
                        bus.rsp_valid = 1'b1;
                        bus.rsp_rdata = pend_data;
                        pending = 0;
                    end else countdown--;
                end
                if (stray_req) begin
                    bus.rsp_valid = 1'b1;
                    bus.rsp_rdata = 16'hFFFF;
                    stray_req = 0;
                end
                if (mon_xfer) begin
                    if (n_acc != withhold_idx) begin
                        pending   = 1;
                        countdown = $urandom_range(dmax, dmin) - 1;
                        if (mon_xfer_read)
                            pend_data = (poll_rsp_q.size() > 0) ? poll_rsp_q.pop_front() : 16'h0000;
                        else
                            pend_data = 16'($urandom);
                    end
                    n_acc++;
                end
                case (ready_mode)
                    1:       bus.cmd_ready = ($urandom_range(0, 3) != 0);
                    2: begin
                        bus.cmd_ready = !(n_acc == 2 && hold_cnt < 50);
                        if (!bus.cmd_ready && bus.cmd_valid) hold_cnt++;
                    end
                    default: bus.cmd_ready = 1'b1;
                endcase
            end
        end
    end

    // ---------------- monitor ----------------
    int cyc = 0, start_cyc = 0, last_rsp_cyc = 0, last_acc_cyc = 0, fail_rise_cyc = 0;
    int run_cmd = 0, stall_cnt = 0;
    bit have_rsp = 0, outstanding = 0, prev_valid = 0, prev_stall = 0, prev_fail = 0;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            mon_xfer = 0;
            if (!rst_n) begin
                prev_valid = 0; prev_stall = 0; outstanding = 0; have_rsp = 0;
            end else begin
                if (start && !busy) begin
                    run_cmd = 0; start_cyc = cyc; have_rsp = 0; outstanding = 0; stall_cnt = 0;
                end
                if (prev_stall) check("valid_hold", bus.cmd_valid, 1'b1);
                if (bus.cmd_valid) begin
                    if (!prev_valid) begin
                        if (run_cmd == 0) check("first_cmd_latency", cyc - start_cyc, 1);
                        else if (have_rsp)
                            check("cmd_spacing", cyc - last_rsp_cyc, (run_cmd >= 7) ? PINT + 1 : GAP + 1);
                        check("cmd_while_outstanding", outstanding, 0);
                    end
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_cmd: got 0x%0h with empty expected queue", bus.cmd_reg_addr);
                    end else begin
                        check("cmd_payload", {bus.cmd_write, bus.cmd_phy_addr, bus.cmd_reg_addr, bus.cmd_wdata},
                              exp_q[0]);
                    end
                    if (bus.cmd_ready) begin
                        if (exp_q.size() > 0) void'(exp_q.pop_front());
                        mon_xfer      = 1;
                        mon_xfer_read = !bus.cmd_write;
                        run_cmd++;
                        outstanding   = 1;
                        last_acc_cyc  = cyc;
                    end else stall_cnt++;
                end
                if (bus.rsp_valid && outstanding) begin
                    last_rsp_cyc = cyc;
                    have_rsp     = 1;
                    outstanding  = 0;
                end
                prev_valid = bus.cmd_valid;
                prev_stall = bus.cmd_valid && !bus.cmd_ready;
            end
            if (fail && !prev_fail) fail_rise_cyc = cyc;
            prev_fail = fail;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_end(input string name);
        bit ok = 0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (done || fail) begin ok = 1; break; end
        end
        check({name, "_end_reached"}, ok, 1'b1);
    endtask

    task automatic wait_acc(input int n);
        bit ok = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (n_acc >= n) begin ok = 1; break; end
        end
        check("accept_count_reached", ok, 1'b1);
    endtask

    task automatic finish_case(input string name);
        @(negedge clk);
        check({name, "_done"}, done, exp_done);
        check({name, "_fail"}, fail, !exp_done);
        check({name, "_link_up"}, link_up, exp_link);
        check({name, "_busy"}, busy, 1'b0);
        check({name, "_cmd_valid"}, bus.cmd_valid, 1'b0);
        check({name, "_cmds_left"}, exp_q.size(), 0);
    endtask

    task automatic run_case(input string name, input logic [15:0] polls[$]);
        n_acc = 0; hold_cnt = 0;
        plan_run(polls);
        do_start();
        wait_end(name);
        finish_case(name);
    endtask

    task automatic reset_outputs_check(input string name);
        check({name, "_cmd_valid"}, bus.cmd_valid, 1'b0);
        check({name, "_cmd_write"}, bus.cmd_write, 1'b0);
        check({name, "_reg_addr"},  bus.cmd_reg_addr, 5'h00);
        check({name, "_wdata"},     bus.cmd_wdata, 16'h0000);
        check({name, "_busy"},      busy, 1'b0);
        check({name, "_done"},      done, 1'b0);
        check({name, "_fail"},      fail, 1'b0);
        check({name, "_link_up"},   link_up, 1'b0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [15:0] polls[$];
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_outputs_check("reset");
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Basic: ready tied high, response 20 cycles after each accept, link up on first poll.
        ready_mode = 0; dmin = 20; dmax = 20;
        polls = '{16'h0004};
        run_case("basic", polls);

        // Entry 2 stalled by 50 cycles of cmd_ready low.
        ready_mode = 2; dmin = 1; dmax = 40;
        polls = '{16'h0004 | 16'($urandom)};
        run_case("stall", polls);
        check("stall_cycles", stall_cnt, 50);

        // Two link-down polls, then link up.
        ready_mode = 0;
        polls = '{16'($urandom) & 16'hFFFB, 16'($urandom) & 16'hFFFB, 16'h0004};
        run_case("poll3", polls);

        // Link never comes up: PMAX reads, then fail.
        polls = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
        run_case("poll_max", polls);

        // Response to entry 4 withheld: timeout, then restart from entry 0.
        withhold_idx = 4; n_acc = 0; hold_cnt = 0;
        polls = '{16'h0004};
        plan_run(polls);
        do_start();
        wait_end("timeout");
        @(negedge clk);
        check("timeout_fail", fail, 1'b1);
        check("timeout_done", done, 1'b0);
        check("timeout_busy", busy, 1'b0);
        check("timeout_window", (fail_rise_cyc - last_acc_cyc >= TMO) && (fail_rise_cyc - last_acc_cyc <= TMO + 2), 1'b1);
        check("timeout_cmds_left", exp_q.size(), 2);
        exp_q.delete();
        withhold_idx = -1;
        run_case("restart", polls);

        // Asynchronous reset during the wait for entry 3's response.
        n_acc = 0; hold_cnt = 0;
        plan_run(polls);
        do_start();
        wait_acc(4);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 reset_outputs_check("async_reset");
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        stray_req = 1;
        repeat (6) @(negedge clk);
        check("stray_rsp_cmd_valid", bus.cmd_valid, 1'b0);
        check("stray_rsp_busy", busy, 1'b0);

        // Start pulse while busy must not restart the sequence.
        n_acc = 0; hold_cnt = 0;
        ready_mode = 1;
        polls = '{16'h0000, 16'h0004};
        plan_run(polls);
        do_start();
        wait_acc(2);
        do_start();
        @(negedge clk);
        check("start_while_busy_busy", busy, 1'b1);
        wait_end("busy_start");
        finish_case("busy_start");

        // Randomized runs.
        for (int r = 0; r < 4; r++) begin
            int n;
            ready_mode = $urandom_range(0, 1);
            dmin = 1; dmax = $urandom_range(1, 40);
            polls.delete();
            n = $urandom_range(0, 4);
            for (int k = 0; k < n; k++) polls.push_back(16'($urandom) & (($urandom_range(0, 2) == 0) ? 16'hFFFF : 16'hFFFB));
            run_case($sformatf("rand%0d", r), polls);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
